order_book_levels: RTL and testbench

Parametrised single-side price-level book: holds the best `DEPTH` aggregated price levels for one instrument side and applies add/reduce updates from the ITCH order engine. It is the successor to the fixed 5-deep buy/sell level arrays inside `order_book_inst`. Depth, widths and sort direction are generic, and it adds quantity reduction, level removal with shift-up, and eviction/miss reporting. One instance serves the buy side and one the sell side, both in the 250 MHz book domain.

---
 rtl/book_pkg.sv | 24 ++
 rtl/level_locate.sv | 42 ++++
 rtl/order_book_levels.sv | 182 ++++++++++++++++++
 tb/tb_order_book_levels.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/book_pkg.sv
// Shared types for the price-level book: update op codes, FSM states and the
// level record used when a level is handled as one unit.
package book_pkg;

  localparam int PRICE_W_DEF = 32;
  localparam int QUANT_W_DEF = 32;

  typedef enum logic {
    ADD    = 1'b0,
    REDUCE = 1'b1
  } bookOpType;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CMP   = 2'd1,
    APPLY = 2'd2
  } bookStateType;

  typedef struct packed {
    logic [PRICE_W_DEF-1:0] price;
    logic [QUANT_W_DEF-1:0] quant;
  } bookLevelType;

endpackage

// File: rtl/level_locate.sv
// Parallel compare of one update price against every occupied level: finds an
// equal-price level and the first level the new price beats.
module level_locate #(
  parameter int DEPTH   = 5,
  parameter int PRICE_W = 32,
  parameter bit IS_BUY  = 1'b1,
  parameter int IDX_W   = $clog2(DEPTH + 2)
) (
  input  logic [PRICE_W-1:0] price_i,
  input  logic [PRICE_W-1:0] level_price_i [1:DEPTH],
  input  logic [IDX_W-1:0]   level_cnt_i,
  output logic               hit_o,
  output logic [IDX_W-1:0]   hit_idx_o,
  output logic [IDX_W-1:0]   ins_idx_o
);

  logic found;
  logic beats;

  always_comb begin
    hit_o     = 1'b0;
    hit_idx_o = IDX_W'(1);
    ins_idx_o = level_cnt_i + IDX_W'(1);
    found     = 1'b0;
    beats     = 1'b0;
    for (int i = 1; i <= DEPTH; i++) begin
      if (IDX_W'(i) <= level_cnt_i) begin
        if (!hit_o && (level_price_i[i] == price_i)) begin
          hit_o     = 1'b1;
          hit_idx_o = IDX_W'(i);
        end
        // Buy side ranks higher prices first, sell side lower prices first.
        beats = IS_BUY ? (price_i > level_price_i[i]) : (price_i < level_price_i[i]);
        if (!found && beats) begin
          found     = 1'b1;
          ins_idx_o = IDX_W'(i);
        end
      end
    end
  end

endmodule

// File: rtl/order_book_levels.sv
// Single-side aggregated price-level book. Each update runs IDLE -> CMP -> APPLY;
// handshake: an update is taken on a clock edge where updValidIn and updReadyOut are both high.
module order_book_levels
  import book_pkg::*;
#(
  parameter int DEPTH   = 5,
  parameter int PRICE_W = 32,
  parameter int QUANT_W = 32,
  parameter bit IS_BUY  = 1'b1
) (
  input  logic                       clkIn,
  input  logic                       rstIn,
  input  logic                       updValidIn,
  output logic                       updReadyOut,
  input  logic                       updOpIn,
  input  logic [PRICE_W-1:0]         updPriceIn,
  input  logic [QUANT_W-1:0]         updQuantIn,
  output logic [PRICE_W-1:0]         priceLevelsOut [1:DEPTH],
  output logic [QUANT_W-1:0]         quantLevelsOut [1:DEPTH],
  output logic [$clog2(DEPTH+1)-1:0] levelCntOut,
  output logic                       updatedOut,
  output logic                       evictOut,
  output logic                       missOut,
  output bookStateType               dbgStateOut
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int IDX_W = $clog2(DEPTH + 2);
  localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(DEPTH);
  localparam logic [IDX_W-1:0] IDX_DEPTH = IDX_W'(DEPTH);

  bookStateType         state_q, state_d;
  bookOpType            op_q;
  logic [PRICE_W-1:0]   price_q;
  logic [QUANT_W-1:0]   quant_q;
  logic                 hit_q;
  logic [IDX_W-1:0]     hit_idx_q, ins_idx_q;
  logic [PRICE_W-1:0]   lvl_price_q [1:DEPTH];
  logic [PRICE_W-1:0]   lvl_price_d [1:DEPTH];
  logic [QUANT_W-1:0]   lvl_quant_q [1:DEPTH];
  logic [QUANT_W-1:0]   lvl_quant_d [1:DEPTH];
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 upd_q, upd_d, evict_q, evict_d, miss_q, miss_d;

  logic                 loc_hit;
  logic [IDX_W-1:0]     loc_hit_idx, loc_ins_idx, cnt_ext;
  logic [QUANT_W-1:0]   hit_quant;
  logic [QUANT_W:0]     sum;

  assign cnt_ext = IDX_W'(cnt_q);

  level_locate #(
    .DEPTH  (DEPTH),
    .PRICE_W(PRICE_W),
    .IS_BUY (IS_BUY),
    .IDX_W  (IDX_W)
  ) u_locate (
    .price_i      (price_q),
    .level_price_i(lvl_price_q),
    .level_cnt_i  (cnt_ext),
    .hit_o        (loc_hit),
    .hit_idx_o    (loc_hit_idx),
    .ins_idx_o    (loc_ins_idx)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (updValidIn) state_d = CMP;
      CMP:     state_d = APPLY;
      APPLY:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    lvl_price_d = lvl_price_q;
    lvl_quant_d = lvl_quant_q;
    cnt_d       = cnt_q;
    upd_d       = 1'b0;
    evict_d     = 1'b0;
    miss_d      = 1'b0;
    hit_quant   = '0;
    for (int i = 1; i <= DEPTH; i++) begin
      if (IDX_W'(i) == hit_idx_q) hit_quant = lvl_quant_q[i];
    end
    sum = {1'b0, hit_quant} + {1'b0, quant_q};
    if (state_q == APPLY) begin
      if ((quant_q == '0) || ((op_q == ADD) && (price_q == '0))) begin
        miss_d = 1'b1;
      end else if ((op_q == ADD) && hit_q) begin
        for (int i = 1; i <= DEPTH; i++) begin
          if (IDX_W'(i) == hit_idx_q) lvl_quant_d[i] = sum[QUANT_W] ? '1 : sum[QUANT_W-1:0];
        end
        // An already saturated level does not change.
        upd_d = ~&hit_quant;
      end else if ((op_q == ADD) && (ins_idx_q <= IDX_DEPTH)) begin
        for (int i = 2; i <= DEPTH; i++) begin
          if (IDX_W'(i) > ins_idx_q) begin
            lvl_price_d[i] = lvl_price_q[i-1];
            lvl_quant_d[i] = lvl_quant_q[i-1];
          end
        end
        for (int i = 1; i <= DEPTH; i++) begin
          if (IDX_W'(i) == ins_idx_q) begin
            lvl_price_d[i] = price_q;
            lvl_quant_d[i] = quant_q;
          end
        end
        evict_d = (cnt_q == FULL_CNT);
        if (cnt_q != FULL_CNT) cnt_d = cnt_q + CNT_W'(1);
        upd_d = 1'b1;
      end else if ((op_q == ADD) || !hit_q) begin
        miss_d = 1'b1;
      end else if (quant_q < hit_quant) begin
        for (int i = 1; i <= DEPTH; i++) begin
          if (IDX_W'(i) == hit_idx_q) lvl_quant_d[i] = hit_quant - quant_q;
        end
        upd_d = 1'b1;
      end else begin
        for (int i = 1; i < DEPTH; i++) begin
          if (IDX_W'(i) >= hit_idx_q) begin
            lvl_price_d[i] = lvl_price_q[i+1];
            lvl_quant_d[i] = lvl_quant_q[i+1];
          end
        end
        lvl_price_d[DEPTH] = '0;
        lvl_quant_d[DEPTH] = '0;
        cnt_d = cnt_q - CNT_W'(1);
        upd_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clkIn) begin
    if (rstIn) begin
      state_q   <= IDLE;
      op_q      <= ADD;
      price_q   <= '0;
      quant_q   <= '0;
      hit_q     <= 1'b0;
      hit_idx_q <= '0;
      ins_idx_q <= '0;
      for (int i = 1; i <= DEPTH; i++) begin
        lvl_price_q[i] <= '0;
        lvl_quant_q[i] <= '0;
      end
      cnt_q   <= '0;
      upd_q   <= 1'b0;
      evict_q <= 1'b0;
      miss_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if ((state_q == IDLE) && updValidIn) begin
        op_q    <= bookOpType'(updOpIn);
        price_q <= updPriceIn;
        quant_q <= updQuantIn;
      end
      if (state_q == CMP) begin
        hit_q     <= loc_hit;
        hit_idx_q <= loc_hit_idx;
        ins_idx_q <= loc_ins_idx;
      end
      lvl_price_q <= lvl_price_d;
      lvl_quant_q <= lvl_quant_d;
      cnt_q       <= cnt_d;
      upd_q       <= upd_d;
      evict_q     <= evict_d;
      miss_q      <= miss_d;
    end
  end

  assign updReadyOut    = (state_q == IDLE);
  assign priceLevelsOut = lvl_price_q;
  assign quantLevelsOut = lvl_quant_q;
  assign levelCntOut    = cnt_q;
  assign updatedOut     = upd_q;
  assign evictOut       = evict_q;
  assign missOut        = miss_q;
  assign dbgStateOut    = state_q;

endmodule

// File: tb/tb_order_book_levels.sv
// Directed bench for one buy-side and one sell-side book sharing a clock and reset.
module tb_order_book_levels;
  import book_pkg::*;

  localparam int DEPTH = 5;
  localparam int PW    = 32;
  localparam int QW    = 32;
  localparam int CW    = $clog2(DEPTH + 1);

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          b_valid, b_ready, b_op, b_upd, b_evict, b_miss;
  logic [PW-1:0] b_price;
  logic [QW-1:0] b_quant;
  logic [PW-1:0] b_lp [1:DEPTH];
  logic [QW-1:0] b_lq [1:DEPTH];
  logic [CW-1:0] b_cnt;
  bookStateType  b_state;

  logic          s_valid, s_ready, s_op, s_upd, s_evict, s_miss;
  logic [PW-1:0] s_price;
  logic [QW-1:0] s_quant;
  logic [PW-1:0] s_lp [1:DEPTH];
  logic [QW-1:0] s_lq [1:DEPTH];
  logic [CW-1:0] s_cnt;
  bookStateType  s_state;

  order_book_levels #(.DEPTH(DEPTH), .PRICE_W(PW), .QUANT_W(QW), .IS_BUY(1'b1)) u_buy (
    .clkIn(clk), .rstIn(rst), .updValidIn(b_valid), .updReadyOut(b_ready),
    .updOpIn(b_op), .updPriceIn(b_price), .updQuantIn(b_quant),
    .priceLevelsOut(b_lp), .quantLevelsOut(b_lq), .levelCntOut(b_cnt),
    .updatedOut(b_upd), .evictOut(b_evict), .missOut(b_miss), .dbgStateOut(b_state)
  );

  order_book_levels #(.DEPTH(DEPTH), .PRICE_W(PW), .QUANT_W(QW), .IS_BUY(1'b0)) u_sell (
    .clkIn(clk), .rstIn(rst), .updValidIn(s_valid), .updReadyOut(s_ready),
    .updOpIn(s_op), .updPriceIn(s_price), .updQuantIn(s_quant),
    .priceLevelsOut(s_lp), .quantLevelsOut(s_lq), .levelCntOut(s_cnt),
    .updatedOut(s_upd), .evictOut(s_evict), .missOut(s_miss), .dbgStateOut(s_state)
  );

  int n_cmp = 0;
  int n_err = 0;

  logic p_upd, p_evict, p_miss, p_early, p_rdy1, p_rdy2;
  logic [PW-1:0] exp_p [1:DEPTH];
  logic [QW-1:0] exp_q [1:DEPTH];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_levels(input bit sell, input string tag, input int cnt);
    for (int i = 1; i <= DEPTH; i++) begin
      chk($sformatf("%s_p%0d", tag, i), 64'(sell ? s_lp[i] : b_lp[i]), 64'(exp_p[i]));
      chk($sformatf("%s_q%0d", tag, i), 64'(sell ? s_lq[i] : b_lq[i]), 64'(exp_q[i]));
    end
    chk({tag, "_cnt"}, 64'(sell ? s_cnt : b_cnt), 64'(cnt));
  endtask

  // Called just after a negedge; returns just after the negedge following the result edge.
  task automatic send(input bit sell, input logic op, input logic [PW-1:0] p, input logic [QW-1:0] q);
    int guard = 0;
    while (!(sell ? s_ready : b_ready) && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 20) chk("ready_timeout", 64'(0), 64'(1));
    if (sell) begin s_valid = 1'b1; s_op = op; s_price = p; s_quant = q; end
    else      begin b_valid = 1'b1; b_op = op; b_price = p; b_quant = q; end
    @(posedge clk);
    @(negedge clk);
    b_valid = 1'b0;
    s_valid = 1'b0;
    p_rdy1 = sell ? s_ready : b_ready;
    @(negedge clk);
    p_rdy2  = sell ? s_ready : b_ready;
    p_early = sell ? s_upd : b_upd;
    @(negedge clk);
    p_upd   = sell ? s_upd : b_upd;
    p_evict = sell ? s_evict : b_evict;
    p_miss  = sell ? s_miss : b_miss;
  endtask

  task automatic chk_pulses(input string tag, input logic u, input logic e, input logic m);
    chk({tag, "_upd"}, 64'(p_upd), 64'(u));
    chk({tag, "_evict"}, 64'(p_evict), 64'(e));
    chk({tag, "_miss"}, 64'(p_miss), 64'(m));
  endtask

  initial begin
    rst = 1'b1;
    b_valid = 1'b0; b_op = 1'b0; b_price = '0; b_quant = '0;
    s_valid = 1'b0; s_op = 1'b0; s_price = '0; s_quant = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_ready", 64'(b_ready), 64'(1));
    chk("rst_state", 64'(b_state), 64'(IDLE));
    chk("rst_pulses", 64'({b_upd, b_evict, b_miss, s_upd, s_evict, s_miss}), 64'(0));
    exp_p = '{default: '0};
    exp_q = '{default: '0};
    chk_levels(1'b0, "rst_buy", 0);

    // Buy side: build, aggregate, insert in the middle, fill.
    send(1'b0, 1'b0, 32'h0022FEFC, 32'h45);
    chk("add1_rdy1", 64'(p_rdy1), 64'(0));
    chk("add1_rdy2", 64'(p_rdy2), 64'(0));
    chk("add1_early", 64'(p_early), 64'(0));
    chk_pulses("add1", 1'b1, 1'b0, 1'b0);
    send(1'b0, 1'b0, 32'h0022FEFC, 32'h555);
    chk("add2_early", 64'(p_early), 64'(0));
    chk_pulses("add2", 1'b1, 1'b0, 1'b0);
    exp_p[1] = 32'h0022FEFC; exp_q[1] = 32'h59A;
    chk_levels(1'b0, "agg", 1);

    send(1'b0, 1'b0, 32'h00224000, 32'h554);
    send(1'b0, 1'b0, 32'h00224000, 32'h553);
    send(1'b0, 1'b0, 32'h00222000, 32'h552);
    send(1'b0, 1'b0, 32'h00221000, 32'h551);
    send(1'b0, 1'b0, 32'h00222001, 32'h123123);
    chk_pulses("mid", 1'b1, 1'b0, 1'b0);
    exp_p = '{32'h0022FEFC, 32'h00224000, 32'h00222001, 32'h00222000, 32'h00221000};
    exp_q = '{32'h59A, 32'hAA7, 32'h123123, 32'h552, 32'h551};
    chk_levels(1'b0, "full", 5);

    send(1'b0, 1'b0, 32'hFFFFFFFF, 32'h01010101);
    chk_pulses("top", 1'b1, 1'b1, 1'b0);
    exp_p = '{32'hFFFFFFFF, 32'h0022FEFC, 32'h00224000, 32'h00222001, 32'h00222000};
    exp_q = '{32'h01010101, 32'h59A, 32'hAA7, 32'h123123, 32'h552};
    chk_levels(1'b0, "evict", 5);
    @(negedge clk);
    chk("evict_oneshot", 64'(b_evict), 64'(0));

    send(1'b0, 1'b0, 32'h00000001, 32'h5);
    chk_pulses("worse", 1'b0, 1'b0, 1'b1);
    chk_levels(1'b0, "worse", 5);
    send(1'b0, 1'b0, 32'h00300000, 32'h0);
    chk_pulses("qty0", 1'b0, 1'b0, 1'b1);
    send(1'b0, 1'b0, 32'h0, 32'h7);
    chk_pulses("price0", 1'b0, 1'b0, 1'b1);
    chk_levels(1'b0, "nochg", 5);

    send(1'b0, 1'b1, 32'h0022FEFC, 32'h45);
    chk_pulses("red", 1'b1, 1'b0, 1'b0);
    chk("red_q2", 64'(b_lq[2]), 64'(32'h555));
    send(1'b0, 1'b1, 32'h0022FEFC, 32'h600);
    chk_pulses("remove", 1'b1, 1'b0, 1'b0);
    exp_p = '{32'hFFFFFFFF, 32'h00224000, 32'h00222001, 32'h00222000, 32'h0};
    exp_q = '{32'h01010101, 32'hAA7, 32'h123123, 32'h552, 32'h0};
    chk_levels(1'b0, "remove", 4);

    // Saturating aggregate, then a further add that cannot change the level.
    send(1'b0, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF);
    chk_pulses("sat", 1'b1, 1'b0, 1'b0);
    chk("sat_q1", 64'(b_lq[1]), 64'(32'hFFFFFFFF));
    send(1'b0, 1'b0, 32'hFFFFFFFF, 32'h3);
    chk_pulses("sat2", 1'b0, 1'b0, 1'b0);
    chk("sat2_q1", 64'(b_lq[1]), 64'(32'hFFFFFFFF));

    // Sell side ascending order and a REDUCE miss.
    send(1'b1, 1'b0, 32'h300, 32'h1);
    send(1'b1, 1'b0, 32'h100, 32'h1);
    send(1'b1, 1'b0, 32'h200, 32'h1);
    chk_pulses("sell_add", 1'b1, 1'b0, 1'b0);
    exp_p = '{32'h100, 32'h200, 32'h300, 32'h0, 32'h0};
    exp_q = '{32'h1, 32'h1, 32'h1, 32'h0, 32'h0};
    chk_levels(1'b1, "sell", 3);
    send(1'b1, 1'b1, 32'h150, 32'h1);
    chk_pulses("sell_miss", 1'b0, 1'b0, 1'b1);
    chk_levels(1'b1, "sell_miss", 3);

    // Reset in the cycle after acceptance aborts the update.
    s_valid = 1'b1; s_op = 1'b0; s_price = 32'h50; s_quant = 32'h9;
    @(posedge clk);
    @(negedge clk);
    s_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_ready", 64'(s_ready), 64'(1));
    chk("abort_state", 64'(s_state), 64'(IDLE));
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("abort_pulse%0d", k), 64'({s_upd, s_evict, s_miss}), 64'(0));
      @(negedge clk);
    end
    exp_p = '{default: '0};
    exp_q = '{default: '0};
    chk_levels(1'b1, "abort", 0);
    chk_levels(1'b0, "abort_buy", 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
